// File: rtl/gpreg_file_wb.sv
// General-purpose register file: three forwarding read ports, one write port,
// a one-entry registered write-back stage and a stallable flags register.
module gpreg_file_wb #(
    parameter int WIDTH      = 8,
    parameter int NUM_REGS   = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int FLAG_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      STALL,
    input  logic                      WR_EN,
    input  logic [IDX_WIDTH-1:0]      WR_IDX,
    input  logic [WIDTH-1:0]          WR_DATA,
    input  logic [IDX_WIDTH-1:0]      LHS_IDX,
    input  logic [IDX_WIDTH-1:0]      RHS_IDX,
    input  logic [IDX_WIDTH-1:0]      MAIN_IDX,
    output logic [WIDTH-1:0]          LHS_DATA,
    output logic [WIDTH-1:0]          RHS_DATA,
    output logic [WIDTH-1:0]          MAIN_DATA,
    input  logic                      FLAGS_EN,
    input  logic [FLAG_WIDTH-1:0]     FLAGS_IN,
    output logic [FLAG_WIDTH-1:0]     FLAGS,
    output logic                      PENDING,
    output logic [NUM_REGS*WIDTH-1:0] DISPLAY
);

    localparam int unsigned NR = NUM_REGS;

    logic [WIDTH-1:0]      regs [NUM_REGS];
    logic                  wb_valid;
    logic [IDX_WIDTH-1:0]  wb_idx;
    logic [WIDTH-1:0]      wb_data;
    logic [FLAG_WIDTH-1:0] flags;
    logic                  accepted;

    logic [IDX_WIDTH-1:0]  rd_idx  [3];
    logic [WIDTH-1:0]      rd_data [3];

    function automatic logic in_range(input logic [IDX_WIDTH-1:0] idx);
        return 32'(idx) < NR;
    endfunction

    assign accepted = WR_EN & ~STALL & in_range(WR_IDX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned r = 0; r < NR; r++) begin
                regs[r] <= '0;
            end
            wb_valid <= 1'b0;
            wb_idx   <= '0;
            wb_data  <= '0;
            flags    <= '0;
        end else if (!STALL) begin
            // Commit the held write and capture the new one on the same edge.
            for (int unsigned r = 0; r < NR; r++) begin
                if (wb_valid && wb_idx == IDX_WIDTH'(r)) begin
                    regs[r] <= wb_data;
                end
            end
            wb_valid <= accepted;
            wb_idx   <= WR_IDX;
            wb_data  <= WR_DATA;
            if (FLAGS_EN) begin
                flags <= FLAGS_IN;
            end
        end
    end

    assign rd_idx[0] = LHS_IDX;
    assign rd_idx[1] = RHS_IDX;
    assign rd_idx[2] = MAIN_IDX;

    // Same-cycle write beats the WB entry, which beats the committed array.
    always_comb begin
        for (int unsigned p = 0; p < 3; p++) begin
            rd_data[p] = '0;
            if (in_range(rd_idx[p])) begin
                if (accepted && WR_IDX == rd_idx[p]) begin
                    rd_data[p] = WR_DATA;
                end else if (wb_valid && wb_idx == rd_idx[p]) begin
                    rd_data[p] = wb_data;
                end else begin
                    for (int unsigned r = 0; r < NR; r++) begin
                        if (rd_idx[p] == IDX_WIDTH'(r)) begin
                            rd_data[p] = regs[r];
                        end
                    end
                end
            end
        end
    end

    assign LHS_DATA  = rd_data[0];
    assign RHS_DATA  = rd_data[1];
    assign MAIN_DATA = rd_data[2];
    assign FLAGS     = flags;
    assign PENDING   = wb_valid;

    always_comb begin
        DISPLAY = '0;
        for (int unsigned r = 0; r < NR; r++) begin
            DISPLAY[r*WIDTH +: WIDTH] = regs[r];
        end
    end

endmodule

// File: tb/tb_gpreg_file_wb.sv
// Scoreboard bench for gpreg_file_wb: a 4-register build and a 3-register build
// share stimulus; expectations are queued by the driver and checked by a monitor.
module tb_gpreg_file_wb;

    logic       clk = 1'b0;
    logic       rst, stall, wr_en, flags_en;
    logic [1:0] wr_idx, lhs_idx, rhs_idx, main_idx;
    logic [7:0] wr_data, flags_in;

    logic [7:0]  lhs_data, rhs_data, main_data, flags;
    logic        pending;
    logic [31:0] display;

    logic [7:0]  lhs3, rhs3, main3, flags3;
    logic        pending3;
    logic [23:0] display3;

    always #5 clk = ~clk;

    gpreg_file_wb #(.WIDTH(8), .NUM_REGS(4), .IDX_WIDTH(2), .FLAG_WIDTH(8)) dut (
        .CLK(clk), .RST(rst), .STALL(stall), .WR_EN(wr_en), .WR_IDX(wr_idx),
        .WR_DATA(wr_data), .LHS_IDX(lhs_idx), .RHS_IDX(rhs_idx), .MAIN_IDX(main_idx),
        .LHS_DATA(lhs_data), .RHS_DATA(rhs_data), .MAIN_DATA(main_data),
        .FLAGS_EN(flags_en), .FLAGS_IN(flags_in), .FLAGS(flags),
        .PENDING(pending), .DISPLAY(display)
    );

    gpreg_file_wb #(.WIDTH(8), .NUM_REGS(3), .IDX_WIDTH(2), .FLAG_WIDTH(8)) dut3 (
        .CLK(clk), .RST(rst), .STALL(stall), .WR_EN(wr_en), .WR_IDX(wr_idx),
        .WR_DATA(wr_data), .LHS_IDX(lhs_idx), .RHS_IDX(rhs_idx), .MAIN_IDX(main_idx),
        .LHS_DATA(lhs3), .RHS_DATA(rhs3), .MAIN_DATA(main3),
        .FLAGS_EN(flags_en), .FLAGS_IN(flags_in), .FLAGS(flags3),
        .PENDING(pending3), .DISPLAY(display3)
    );

    typedef struct {
        int          code;
        int          cyc;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int    passed = 0;
    int    total  = 0;
    int    cyc    = 0;

    function automatic logic [31:0] get_sig(input int code);
        case (code)
            0: return {24'd0, lhs_data};
            1: return {24'd0, rhs_data};
            2: return {24'd0, main_data};
            3: return {24'd0, flags};
            4: return {31'd0, pending};
            5: return display;
            6: return {24'd0, lhs3};
            7: return {24'd0, flags3};
            8: return {31'd0, pending3};
            default: return {8'd0, display3};
        endcase
    endfunction

    function automatic string sig_name(input int code);
        case (code)
            0: return "LHS_DATA";
            1: return "RHS_DATA";
            2: return "MAIN_DATA";
            3: return "FLAGS";
            4: return "PENDING";
            5: return "DISPLAY";
            6: return "LHS_DATA(n3)";
            7: return "FLAGS(n3)";
            8: return "PENDING(n3)";
            default: return "DISPLAY(n3)";
        endcase
    endfunction

    // Monitor: drains every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            item_t it;
            logic [31:0] act;
            it  = sb.pop_front();
            act = get_sig(it.code);
            total++;
            if (act === it.exp) begin
                passed++;
            end else begin
                $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                         sig_name(it.code), it.cyc, act, it.exp);
            end
        end
    end

    task automatic expect_sig(input int code, input logic [31:0] value);
        item_t it;
        it.code = code;
        it.cyc  = cyc;
        it.exp  = value;
        sb.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic en, input logic [1:0] idx, input logic [7:0] data);
        wr_en   = en;
        wr_idx  = idx;
        wr_data = data;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flags_en = 1'b0; flags_in = 8'h00;
        wr(1'b0, 2'd0, 8'h00);
        lhs_idx = 2'd0; rhs_idx = 2'd0; main_idx = 2'd0;

        // Reset then idle
        step();
        rst = 1'b0;
        expect_sig(0, 0); expect_sig(1, 0); expect_sig(2, 0);
        expect_sig(3, 0); expect_sig(4, 0); expect_sig(5, 0);

        // Bypass chain on r0
        step();
        wr(1'b1, 2'd0, 8'h11);
        expect_sig(0, 32'h11); expect_sig(4, 0); expect_sig(5, 0);
        step();
        wr(1'b0, 2'd0, 8'h00);
        expect_sig(0, 32'h11); expect_sig(4, 1); expect_sig(5, 0);
        step();
        expect_sig(0, 32'h11); expect_sig(4, 0); expect_sig(5, 32'h0000_0011);

        // Back-to-back writes to r2
        step();
        rhs_idx = 2'd2;
        wr(1'b1, 2'd2, 8'hA5);
        expect_sig(1, 32'hA5);
        step();
        wr(1'b1, 2'd2, 8'h5A);
        expect_sig(1, 32'h5A); expect_sig(4, 1);
        step();
        wr(1'b0, 2'd0, 8'h00);
        expect_sig(1, 32'h5A); expect_sig(5, 32'h00A5_0011);
        step();
        expect_sig(1, 32'h5A); expect_sig(4, 0); expect_sig(5, 32'h005A_0011);

        // Stall with a pending write to r1 and a blocked write of 0xFF
        step();
        main_idx = 2'd1;
        wr(1'b1, 2'd1, 8'h33);
        expect_sig(2, 32'h33);
        for (int i = 0; i < 3; i++) begin
            step();
            stall = 1'b1;
            wr(1'b1, 2'd1, 8'hFF);
            expect_sig(2, 32'h33); expect_sig(4, 1); expect_sig(5, 32'h005A_0011);
        end
        step();
        stall = 1'b0;
        wr(1'b0, 2'd0, 8'h00);
        expect_sig(2, 32'h33); expect_sig(4, 1); expect_sig(5, 32'h005A_0011);
        step();
        expect_sig(2, 32'h33); expect_sig(4, 0); expect_sig(5, 32'h005A_3311);

        // Flags capture, hold and stall hold
        step();
        flags_en = 1'b1; flags_in = 8'h02;
        expect_sig(3, 0); expect_sig(7, 0);
        step();
        flags_en = 1'b0; flags_in = 8'hAA;
        expect_sig(3, 32'h02); expect_sig(7, 32'h02);
        step();
        expect_sig(3, 32'h02);
        step();
        stall = 1'b1; flags_en = 1'b1; flags_in = 8'h81;
        expect_sig(3, 32'h02);
        step();
        stall = 1'b0; flags_en = 1'b0;
        expect_sig(3, 32'h02); expect_sig(7, 32'h02);

        // Index 3: out of range on the 3-register build, valid on the 4-register one
        step();
        lhs_idx = 2'd3;
        wr(1'b1, 2'd3, 8'h99);
        expect_sig(6, 0); expect_sig(0, 32'h99);
        step();
        wr(1'b0, 2'd0, 8'h00);
        expect_sig(6, 0); expect_sig(8, 0); expect_sig(4, 1);
        step();
        expect_sig(9, 32'h005A_3311); expect_sig(5, 32'h995A_3311); expect_sig(6, 0);

        // Reset discards a pending write to r3
        step();
        main_idx = 2'd3;
        wr(1'b1, 2'd3, 8'h77);
        expect_sig(2, 32'h77);
        step();
        rst = 1'b1;
        wr(1'b0, 2'd0, 8'h00);
        expect_sig(2, 32'h77); expect_sig(4, 1);
        step();
        rst = 1'b0;
        expect_sig(2, 0); expect_sig(4, 0); expect_sig(5, 0); expect_sig(3, 0);
        step();
        expect_sig(2, 0); expect_sig(5, 0); expect_sig(9, 0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
